tile_skew_feeder: RTL and testbench

//  Upstream stage of the 8x8 output-stationary systolic tile. Accepts one unskewed

---
 rtl/tile_skew_feeder_if.sv | 25 ++
 rtl/tile_skew_feeder.sv | 138 +++++++++++++
 tb/tb_tile_skew_feeder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_skew_feeder_if.sv
// Beat handshake between the wavefront source and the skew feeder.
// One unskewed A column and B row per accepted beat.
interface tile_skew_feeder_if #(
  parameter int N = 8,
  parameter int W = 16
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [N*W-1:0] A_COL;
  logic [N*W-1:0] B_ROW;

  modport master (
    output IN_VALID,
    output A_COL,
    output B_ROW,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID,
    input  A_COL,
    input  B_ROW,
    output IN_READY
  );
endinterface

// File: rtl/tile_skew_feeder.sv
// Skews unskewed A/B wavefronts onto the west and north edges of the
// systolic tile, then zero-drains it; the tile steps only on advance.
module tile_skew_feeder #(
  parameter int N         = 8,
  parameter int W         = 16,
  parameter int KW        = 8,
  parameter int DRAIN_LEN = 3*N-1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [KW-1:0]       K_LEN,
  tile_skew_feeder_if.slave   feed,
  output logic [N*W-1:0]      R_X,
  output logic [N*W-1:0]      C_X,
  output logic                TILE_EN,
  output logic                BUSY,
  output logic                DONE
);

  localparam int TOT = N*(N+1)/2;
  localparam logic [5:0] DRAIN_LAST = 6'(DRAIN_LEN-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_len_q, k_len_d;
  logic [KW-1:0]       beat_q, beat_d;
  logic [5:0]          drain_q, drain_d;
  // Triangular storage: lane i owns entries i*(i+1)/2 .. +i
  logic [TOT-1:0][W-1:0] sa_q, sa_d;
  logic [TOT-1:0][W-1:0] sb_q, sb_d;
  logic                advance;
  logic                clr;

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    advance = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          clr     = 1'b1;
          k_len_d = K_LEN;
          beat_d  = '0;
          drain_d = '0;
          state_d = (K_LEN == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (feed.IN_VALID) begin
          advance = 1'b1;
          if (beat_q == k_len_q - 1'b1) begin
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        advance = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    sa_d = sa_q;
    sb_d = sb_q;
    if (clr) begin
      sa_d = '0;
      sb_d = '0;
    end else if (advance) begin
      for (int i = 0; i < N; i++) begin
        for (int d = i; d > 0; d--) begin
          sa_d[i*(i+1)/2 + d] = sa_q[i*(i+1)/2 + d - 1];
          sb_d[i*(i+1)/2 + d] = sb_q[i*(i+1)/2 + d - 1];
        end
        // Drain shifts zeros in behind the last wavefront
        sa_d[i*(i+1)/2] = (state_q == S_FEED) ?
                          feed.A_COL[i*W +: W] : '0;
        sb_d[i*(i+1)/2] = (state_q == S_FEED) ?
                          feed.B_ROW[i*W +: W] : '0;
      end
    end
  end

  always_comb begin
    R_X = '0;
    C_X = '0;
    for (int i = 0; i < N; i++) begin
      R_X[i*W +: W] = sa_q[i*(i+1)/2 + i];
      C_X[i*W +: W] = sb_q[i*(i+1)/2 + i];
    end
  end

  assign feed.IN_READY = (state_q == S_FEED);
  assign TILE_EN       = advance;
  assign BUSY          = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign DONE          = (state_q == S_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

endmodule

// File: tb/tb_tile_skew_feeder.sv
// Bench for tile_skew_feeder: scoreboarded skew outputs plus a
// behavioural 8x8 output-stationary tile driven by R_X/C_X/TILE_EN.
module tb_tile_skew_feeder;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int KW = 8;
  localparam int NW = N*W;
  localparam int DL = 3*N-1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic [NW-1:0] r_x;
  logic [NW-1:0] c_x;
  logic          tile_en;
  logic          busy;
  logic          done;

  tile_skew_feeder_if #(.N(N), .W(W)) feed_if ();

  tile_skew_feeder #(.N(N), .W(W), .KW(KW)) dut (
    .CLK     (clk),
    .RST     (rst),
    .START   (start),
    .K_LEN   (k_len),
    .feed    (feed_if),
    .R_X     (r_x),
    .C_X     (c_x),
    .TILE_EN (tile_en),
    .BUSY    (busy),
    .DONE    (done)
  );

  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  logic [NW-1:0] ha[$];
  logic [NW-1:0] hb[$];
  logic [NW-1:0] q_r[$];
  logic [NW-1:0] q_c[$];
  logic [NW-1:0] last_r;
  logic [NW-1:0] last_c;
  logic [NW-1:0] ba[256];
  logic [NW-1:0] bb[256];
  bit start_noise;
  bit tile_clr;

  int acc[N][N];
  int ar[N][N];
  int br[N][N];
  int an[N][N];
  int bn[N][N];

  // Behavioural tile: PEs register a east and b south, accumulate a*b
  always @(posedge clk) begin
    if (tile_clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0;
          ar[i][j]  = 0;
          br[i][j]  = 0;
        end
    end else if (tile_en === 1'b1) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) an[i][j] = int'(r_x[i*W +: W]);
          else        an[i][j] = ar[i][j-1];
          if (i == 0) bn[i][j] = int'(c_x[j*W +: W]);
          else        bn[i][j] = br[i-1][j];
          acc[i][j] = acc[i][j] + an[i][j]*bn[i][j];
        end
      ar = an;
      br = bn;
    end
  end

  function automatic logic [NW-1:0] rnd_beat();
    logic [NW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic cyc(input bit valid, input logic [NW-1:0] a,
                     input logic [NW-1:0] b, input bit adv,
                     input bit drain);
    logic [NW-1:0] er;
    logic [NW-1:0] ec;
    int t;
    @(negedge clk);
    feed_if.IN_VALID = valid;
    feed_if.A_COL    = a;
    feed_if.B_ROW    = b;
    start            = start_noise;
    if (start_noise) k_len = '0;
    #1;
    n_run++;
    if (tile_en !== adv) begin
      n_fail++;
      $display("FAIL tile_en: got %b want %b", tile_en, adv);
    end
    n_run++;
    if (feed_if.IN_READY !== !drain) begin
      n_fail++;
      $display("FAIL in_ready: got %b want %b", feed_if.IN_READY, !drain);
    end
    n_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_done: got %b%b want 10", busy, done);
    end
    if (adv) begin
      ha.push_back(drain ? '0 : a);
      hb.push_back(drain ? '0 : b);
      t  = ha.size() - 1;
      er = '0;
      ec = '0;
      for (int i = 0; i < N; i++)
        if (t >= i) begin
          er[i*W +: W] = ha[t-i][i*W +: W];
          ec[i*W +: W] = hb[t-i][i*W +: W];
        end
      last_r = er;
      last_c = ec;
    end
    q_r.push_back(last_r);
    q_c.push_back(last_c);
    @(posedge clk);
    #1;
    er = q_r.pop_front();
    ec = q_c.pop_front();
    n_run++;
    if (r_x !== er) begin
      n_fail++;
      $display("FAIL r_x: got %h want %h", r_x, er);
    end
    n_run++;
    if (c_x !== ec) begin
      n_fail++;
      $display("FAIL c_x: got %h want %h", c_x, ec);
    end
  endtask

  task automatic job_start(input int k);
    @(negedge clk);
    start            = 1'b1;
    k_len            = KW'(k);
    feed_if.IN_VALID = 1'b0;
    tile_clr         = 1'b1;
    #1;
    n_run++;
    if (tile_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_start: got en=%b busy=%b want 0 0", tile_en, busy);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    tile_clr = 1'b0;
    ha.delete();
    hb.delete();
    last_r = '0;
    last_c = '0;
    n_run++;
    if (r_x !== '0 || c_x !== '0) begin
      n_fail++;
      $display("FAIL start_clear: got %h %h want 0", r_x, c_x);
    end
    n_run++;
    if (busy !== (k != 0)) begin
      n_fail++;
      $display("FAIL start_busy: got %b want %b", busy, (k != 0));
    end
  endtask

  task automatic job_feed(input int k, input int stall_at, input int stall_len);
    for (int b = 0; b < k; b++) begin
      if (b == stall_at)
        for (int s = 0; s < stall_len; s++) cyc(1'b0, rnd_beat(), rnd_beat(), 1'b0, 1'b0);
      cyc(1'b1, ba[b], bb[b], 1'b1, 1'b0);
    end
  endtask

  task automatic job_drain(input int n);
    for (int d = 0; d < n; d++) cyc(1'b1, '1, '1, 1'b1, 1'b1);
  endtask

  task automatic job_finish();
    n_run++;
    if (done !== 1'b1 || busy !== 1'b0 || tile_en !== 1'b0) begin
      n_fail++;
      $display("FAIL done_state: got done=%b busy=%b en=%b want 1 0 0", done, busy, tile_en);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got %b want 0", done);
    end
  endtask

  task automatic run_job(input int k, input int stall_at, input int stall_len);
    job_start(k);
    job_feed(k, stall_at, stall_len);
    job_drain(DL);
    job_finish();
  endtask

  task automatic check_tile_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        n_run++;
        if (acc[i][j] !== j + 1) begin
          n_fail++;
          $display("FAIL tile_y%0d%0d: got %0d want %0d", i, j, acc[i][j], j + 1);
        end
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    feed_if.IN_VALID = 1'b1;
    feed_if.A_COL = rnd_beat();
    feed_if.B_ROW = rnd_beat();
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if (r_x !== '0 || c_x !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h want 0", r_x, c_x);
    end
    n_run++;
    if ({feed_if.IN_READY, tile_en, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {feed_if.IN_READY, tile_en, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    for (int i = 0; i < N; i++) begin
      ba[0][i*W +: W] = W'(i + 1);
      bb[0][i*W +: W] = W'(i + 9);
    end
    run_job(1, -1, 0);
  endtask

  task automatic fill_identity();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        ba[k][i*W +: W] = (i == k) ? W'(1) : W'(0);
        bb[k][i*W +: W] = W'(i + 1);
      end
  endtask

  task automatic test_identity();
    fill_identity();
    run_job(N, -1, 0);
    check_tile_identity();
  endtask

  task automatic test_stall();
    fill_identity();
    run_job(N, 2, 3);
    check_tile_identity();
  endtask

  task automatic test_start_busy();
    for (int b = 0; b < 2; b++) begin
      ba[b] = rnd_beat();
      bb[b] = rnd_beat();
    end
    job_start(2);
    start_noise = 1'b1;
    job_feed(2, 1, 1);
    job_drain(DL);
    start_noise = 1'b0;
    start = 1'b0;
    job_finish();
    @(negedge clk);
    start = 1'b1;
    k_len = '0;
    feed_if.IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_run++;
    if (done !== 1'b1 || busy !== 1'b0 || tile_en !== 1'b0) begin
      n_fail++;
      $display("FAIL klen0_done: got done=%b busy=%b en=%b want 1 0 0", done, busy, tile_en);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (done !== 1'b0 || tile_en !== 1'b0) begin
      n_fail++;
      $display("FAIL klen0_idle: got done=%b en=%b want 0 0", done, tile_en);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) begin
      ba[0][i*W +: W] = W'(i + 1);
      bb[0][i*W +: W] = W'(i + 9);
    end
    job_start(1);
    job_feed(1, -1, 0);
    job_drain(5);
    @(negedge clk);
    rst = 1'b1;
    feed_if.IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    n_run++;
    if (r_x !== '0 || c_x !== '0) begin
      n_fail++;
      $display("FAIL midrst_data: got %h %h want 0", r_x, c_x);
    end
    n_run++;
    if ({feed_if.IN_READY, tile_en, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got %b want 0000",
               {feed_if.IN_READY, tile_en, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_nodone: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    test_single();
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 2; b++) begin
      ba[b] = rnd_beat();
      bb[b] = rnd_beat();
    end
    run_job(2, -1, 0);
    for (int b = 0; b < 3; b++) begin
      ba[b] = rnd_beat();
      bb[b] = rnd_beat();
    end
    run_job(3, -1, 0);
  endtask

  task automatic test_max_len();
    for (int b = 0; b < 255; b++) begin
      ba[b] = rnd_beat();
      bb[b] = rnd_beat();
    end
    run_job(255, 100, 2);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    start_noise = 1'b0;
    tile_clr = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    feed_if.IN_VALID = 1'b0;
    feed_if.A_COL = '0;
    feed_if.B_ROW = '0;
    last_r = '0;
    last_c = '0;
    test_reset();
    test_single();
    test_identity();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
